mmio_store_sink: RTL and testbench

- Memory-mapped responder on the processor data bus: the consuming end of the store interface (memwrite/dataadr/writedata) the core drives.
- Stores that hit its 16-byte window are decoded. DATA-register stores are queued in a FIFO, and software reads status through a combinational read port.
- Queued words drain to downstream logic (e.g. a UART or result checker) over a valid/ready handshake.
- Sits beside data memory; the top level muxes readdata on rd_hit.

---
 rtl/proc_mmio_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/mmio_store_sink.sv | 124 ++++++++++++
 tb/tb_mmio_store_sink.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_mmio_pkg
// Description : Register offsets, STATUS bit positions, CTRL bit positions and
//               a STATUS packing helper for the MMIO store sink.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_mmio_pkg;

  // Register select values taken from dataadr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_TOTAL  = 2'd3;

  // STATUS layout
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 9;
  localparam int STAT_EMPTY     = 16;
  localparam int STAT_FULL      = 17;
  localparam int STAT_OVF       = 24;

  // CTRL layout
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  // Assemble the STATUS word from its fields
  function automatic logic [31:0] pack_status(input logic [STAT_COUNT_W-1:0] count,
                                              input logic empty,
                                              input logic full,
                                              input logic ovf);
    logic [31:0] s;
    s = 32'd0;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO with push/pop/flush and asynchronous reset.
//               Head word is presented combinationally and forced to 0 when
//               the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_CW-1:0]  r_wptr;
  logic [c_CW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic [c_CW-1:0]  w_wptr_nxt;
  logic [c_CW-1:0]  w_rptr_nxt;

  // Pointers wrap modulo DEPTH rather than at the counter width
  assign w_wptr_nxt = (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;

  // Pointer and occupancy state; flush has priority over any pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= w_wptr_nxt;
      if (pop)  r_rptr <= w_rptr_nxt;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty gates the head output
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wptr[c_AW-1:0]] <= wdata;
  end

  assign full  = (r_count == c_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/mmio_store_sink.sv
`default_nettype none
// ============================================================================
// Module      : mmio_store_sink
// Description : Memory-mapped store sink. Decodes a 16-byte window, queues
//               DATA-register stores into a FIFO, exposes STATUS/TOTAL reads
//               and drains queued words over a valid/ready handshake.
//               Optional macro STORE_SINK_ADDR_CAPTURE_EN stores the store
//               address alongside each word and presents it on out_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_store_sink
  import proc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        rd_hit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr
);

  localparam int c_CW = $clog2(DEPTH) + 1;
`ifdef STORE_SINK_ADDR_CAPTURE_EN
  localparam int c_ENTRY_W = 64;
`else
  localparam int c_ENTRY_W = 32;
`endif

  logic                 w_hit;
  logic [1:0]           w_sel;
  logic                 w_wr_data;
  logic                 w_wr_ctrl;
  logic                 w_flush;
  logic                 w_clr_ovf;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CW-1:0]      w_count;
  logic [c_ENTRY_W-1:0] w_fifo_wdata;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 r_ovf;
  logic [31:0]          r_total;
  logic                 w_unused;

  assign w_hit     = (dataadr[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = dataadr[3:2];
  assign w_wr_data = memwrite && w_hit && (w_sel == OFF_DATA);
  assign w_wr_ctrl = memwrite && w_hit && (w_sel == OFF_CTRL);
  assign w_flush   = w_wr_ctrl && writedata[CTRL_FLUSH];
  assign w_clr_ovf = w_wr_ctrl && writedata[CTRL_CLR_OVF];

  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds
  assign w_pop     = out_valid && out_ready && !w_flush;
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_drop    = w_wr_data && w_full && !w_pop;

`ifdef STORE_SINK_ADDR_CAPTURE_EN
  assign w_fifo_wdata = {dataadr, writedata};
  assign out_addr     = w_head[63:32];
`else
  assign w_fifo_wdata = writedata;
  assign out_addr     = 32'd0;
`endif

  assign w_unused = ^{dataadr[1:0]};

  sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (w_fifo_wdata),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_head[31:0];
  assign rd_hit    = w_hit;

  // Sticky overflow flag: set by a dropped store, cleared through CTRL
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (w_clr_ovf) r_ovf <= 1'b0;
  end

  // Running count of accepted pushes, wraps naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_total <= 32'd0;
    else if (w_push) r_total <= r_total + 32'd1;
  end

  // Register read mux; anything outside the window reads as 0
  always_comb begin
    readdata = 32'd0;
    if (w_hit) begin
      case (w_sel)
        OFF_DATA:   readdata = out_data;
        OFF_STATUS: readdata = pack_status(STAT_COUNT_W'(w_count), w_empty, w_full, r_ovf);
        OFF_TOTAL:  readdata = r_total;
        default:    readdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_store_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_store_sink
// Description : Directed self-checking bench for mmio_store_sink (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_store_sink;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rd_hit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;

  int checks;
  int errors;

  localparam logic [31:0] A_DATA   = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0008;
  localparam logic [31:0] A_TOTAL  = 32'hFFFF_000C;

  mmio_store_sink #(
    .BASE_ADDR (32'hFFFF_0000),
    .DEPTH     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .rd_hit    (rd_hit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store, held across a single rising edge
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    dataadr = a;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = 32'd0;
    writedata = 32'd0;
    out_ready = 1'b0;

    // Reset state
    rd(A_STATUS);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_status", readdata, 32'h0001_0000);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single store, then pop
    store(A_DATA, 32'h0000_0007);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", out_data, 32'h7);
    rd(A_STATUS);
    chk("single_status", readdata, 32'h0000_0001);
    rd(A_DATA);
    chk("single_rd_data", readdata, 32'h7);
    rd(A_TOTAL);
    chk("single_total", readdata, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rd(A_STATUS);
    chk("pop_status", readdata, 32'h0001_0000);
    chk("pop_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while a word is waiting
    store(A_DATA, 32'h55);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rd(A_STATUS);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_status", readdata, 32'h0001_0000);
    rd(A_TOTAL);
    chk("async_rst_total", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Fill past capacity with no drain
    for (int i = 1; i <= 9; i++) store(A_DATA, 32'(i));
    rd(A_STATUS);
    chk("fill_status", readdata, 32'h0102_0008);
    rd(A_TOTAL);
    chk("fill_total", readdata, 32'd8);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    rd(A_STATUS);
    chk("drain_status_ovf", readdata, 32'h0101_0000);

    // Clear overflow, refill, then push and pop together while full
    store(A_CTRL, 32'h2);
    rd(A_STATUS);
    chk("clr_ovf_status", readdata, 32'h0001_0000);
    for (int i = 0; i < 8; i++) store(A_DATA, 32'h10 + 32'(i));
    out_ready = 1'b1;
    store(A_DATA, 32'hAA);
    out_ready = 1'b0;
    rd(A_STATUS);
    chk("full_pp_status", readdata, 32'h0002_0008);
    rd(A_TOTAL);
    chk("full_pp_total", readdata, 32'd17);
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("pp_drain_%0d", i), out_data, 32'h10 + 32'(i));
      step();
    end
    chk("pp_drain_last", out_data, 32'hAA);
    step();
    out_ready = 1'b0;
    chk("pp_drain_empty", {31'd0, out_valid}, 32'd0);

    // CTRL flush plus overflow clear with count=5 and overflow set
    for (int i = 0; i < 9; i++) store(A_DATA, 32'h20 + 32'(i));
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    rd(A_STATUS);
    chk("pre_flush_status", readdata, 32'h0100_0005);
    chk("pre_flush_head", out_data, 32'h23);
    store(A_CTRL, 32'h3);
    rd(A_STATUS);
    chk("flush_status", readdata, 32'h0001_0000);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    rd(A_TOTAL);
    chk("flush_total", readdata, 32'd25);
    rd(A_CTRL);
    chk("ctrl_read_zero", readdata, 32'd0);
    chk("ctrl_read_hit", {31'd0, rd_hit}, 32'd1);

    // Decode: out-of-window stores and read-only register writes
    store(32'hFFFF_0010, 32'h99);
    chk("miss_hi_valid", {31'd0, out_valid}, 32'd0);
    chk("miss_hi_hit", {31'd0, rd_hit}, 32'd0);
    chk("miss_hi_rd", readdata, 32'd0);
    store(32'h0000_0000, 32'h98);
    chk("miss_zero_valid", {31'd0, out_valid}, 32'd0);
    chk("miss_zero_hit", {31'd0, rd_hit}, 32'd0);
    chk("miss_zero_rd", readdata, 32'd0);
    store(A_STATUS, 32'h97);
    store(A_TOTAL, 32'h96);
    chk("ro_write_valid", {31'd0, out_valid}, 32'd0);
    rd(A_TOTAL);
    chk("ro_write_total", readdata, 32'd25);

    // Byte offset within DATA is ignored for the push
    store(32'hFFFF_0002, 32'h42);
    chk("sub_word_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_word_data", out_data, 32'h42);
`ifdef STORE_SINK_ADDR_CAPTURE_EN
    chk("sub_word_addr", out_addr, 32'hFFFF_0002);
`else
    chk("sub_word_addr", out_addr, 32'd0);
`endif
    rd(A_TOTAL);
    chk("final_total", readdata, 32'd26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
